// File: rtl/reg_reader_pkg.sv
// Shared widths, register-file types and reader FSM state encoding.
package reg_reader_pkg;

    localparam int REG_W    = 16;
    localparam int SEL_W    = 4;
    localparam int NUM_REGS = 16;

    typedef logic [REG_W-1:0]     word_t;
    typedef logic [SEL_W-1:0]     sel_t;
    typedef word_t [NUM_REGS-1:0] regfile_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/reg_reader_if.sv
// Read-request / read-data handshake plus the register-file snoop signals.
// regs[i] carries register i of the register file.
interface reg_reader_if;
    import reg_reader_pkg::*;

    regfile_t    regs;
    logic        write;
    sel_t        write_select;
    word_t       inputReg;
    logic        rd_req;
    sel_t        sel_a;
    sel_t        sel_b;
    logic        rd_ready;
    logic        rd_valid;
    word_t       data_a;
    word_t       data_b;
    logic        rd_ack;
    logic [15:0] rd_count;

    // Requester / register-file side.
    modport master (
        output regs, write, write_select, inputReg, rd_req, sel_a, sel_b, rd_ack,
        input  rd_ready, rd_valid, data_a, data_b, rd_count
    );

    // Reader side.
    modport slave (
        input  regs, write, write_select, inputReg, rd_req, sel_a, sel_b, rd_ack,
        output rd_ready, rd_valid, data_a, data_b, rd_count
    );

endinterface

// File: rtl/reg_reader_sel_mux.sv
// One read port: 16:1 register select with write bypass and optional
// hard-wired zero for register 0 (zero wins over the bypass).
module reg_sel_mux import reg_reader_pkg::*; #(
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b0
) (
    input  regfile_t regs_i,
    input  sel_t     sel_i,
    input  logic     write_i,
    input  sel_t     write_select_i,
    input  word_t    write_data_i,
    output word_t    data_o
);

    // Pick the read value: zero-r0 override, then same-cycle write, then register.
    always_comb begin
        data_o = regs_i[sel_i];
        if (ZERO_R0 && (sel_i == {SEL_W{1'b0}})) begin
            data_o = {REG_W{1'b0}};
        end else if (BYPASS && write_i && (write_select_i == sel_i)) begin
            data_o = write_data_i;
        end else begin
            data_o = regs_i[sel_i];
        end
    end

endmodule

// File: rtl/reg_reader.sv
// Two-port register-file reader with a one-entry output holding stage.
// A request is captured one cycle after acceptance and held until acked;
// an ack with a new request reloads the stage for one read per cycle.
module reg_reader #(
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    reg_reader_if.slave  bus
);
    import reg_reader_pkg::*;

    localparam logic [0:0] IDLE = ST_IDLE;
    localparam logic [0:0] HOLD = ST_HOLD;

    logic [0:0]  state_q, state_d;
    word_t       data_a_q, data_a_d;
    word_t       data_b_q, data_b_d;
    logic [15:0] count_q, count_d;
    logic        rd_ready_s;
    logic        accept_s;
    word_t       mux_a_s, mux_b_s;

    reg_sel_mux #(.BYPASS(BYPASS), .ZERO_R0(ZERO_R0)) u_mux_a (
        .regs_i         (bus.regs),
        .sel_i          (bus.sel_a),
        .write_i        (bus.write),
        .write_select_i (bus.write_select),
        .write_data_i   (bus.inputReg),
        .data_o         (mux_a_s)
    );

    reg_sel_mux #(.BYPASS(BYPASS), .ZERO_R0(ZERO_R0)) u_mux_b (
        .regs_i         (bus.regs),
        .sel_i          (bus.sel_b),
        .write_i        (bus.write),
        .write_select_i (bus.write_select),
        .write_data_i   (bus.inputReg),
        .data_o         (mux_b_s)
    );

    // Ready when empty, or when the held read is being taken this cycle.
    always_comb begin
        rd_ready_s = (state_q == IDLE) | ((state_q == HOLD) & bus.rd_ack);
        accept_s   = bus.rd_req & rd_ready_s;
    end

    // Next state: capture on accept, drain on ack, otherwise keep the snapshot.
    always_comb begin
        state_d  = state_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        count_d  = count_q;
        if (accept_s) begin
            state_d  = HOLD;
            data_a_d = mux_a_s;
            data_b_d = mux_b_s;
            count_d  = count_q + 16'd1;
        end else if ((state_q == HOLD) && bus.rd_ack) begin
            state_d = IDLE;
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers; reset abandons any held read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            data_a_q <= {REG_W{1'b0}};
            data_b_q <= {REG_W{1'b0}};
            count_q  <= 16'h0000;
        end else begin
            state_q  <= state_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            count_q  <= count_d;
        end
    end

    assign bus.rd_ready = rd_ready_s;
    assign bus.rd_valid = (state_q == HOLD);
    assign bus.data_a   = data_a_q;
    assign bus.data_b   = data_b_q;
    assign bus.rd_count = count_q;

endmodule

// File: tb/tb_reg_reader.sv
// Randomised scoreboard bench for reg_reader. Three instances share the
// stimulus: defaults, BYPASS=0, and ZERO_R0=1.
module tb_reg_reader;
    import reg_reader_pkg::*;

    localparam int ND = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_t    regs_v;
    logic        wr_v;
    sel_t        ws_v;
    word_t       wd_v;
    logic        req_v;
    sel_t        sa_v, sb_v;
    logic        ack_v;

    logic [ND-1:0] rdy_s, val_s;
    word_t         da_s [ND];
    word_t         db_s [ND];
    logic [15:0]   cnt_s [ND];

    reg_reader_if bus [ND] ();

    for (genvar g = 0; g < ND; g++) begin : g_dut
        reg_reader #(.BYPASS(g != 1), .ZERO_R0(g == 2)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus[g])
        );
        assign bus[g].regs         = regs_v;
        assign bus[g].write        = wr_v;
        assign bus[g].write_select = ws_v;
        assign bus[g].inputReg     = wd_v;
        assign bus[g].rd_req       = req_v;
        assign bus[g].sel_a        = sa_v;
        assign bus[g].sel_b        = sb_v;
        assign bus[g].rd_ack       = ack_v;
        assign rdy_s[g]            = bus[g].rd_ready;
        assign val_s[g]            = bus[g].rd_valid;
        assign da_s[g]             = bus[g].data_a;
        assign db_s[g]             = bus[g].data_b;
        assign cnt_s[g]            = bus[g].rd_count;
    end

    typedef struct packed {
        logic [ND-1:0][15:0] a;
        logic [ND-1:0][15:0] b;
        logic [15:0]         cnt;
    } exp_t;

    exp_t        exp_q [$];
    exp_t        last_e;
    int          n_vec  = 0;
    int          n_miss = 0;
    bit          m_held = 1'b0;
    logic [15:0] m_count = 16'h0000;
    logic [ND-1:0] acc_prev = '0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit byp_of(int d);
        return d != 1;
    endfunction

    function automatic bit zr_of(int d);
        return d == 2;
    endfunction

    // What a read of register `sel` should return this cycle for instance d.
    function automatic word_t ref_val(int d, sel_t sel);
        if (zr_of(d) && sel == 4'd0) return 16'h0000;
        if (byp_of(d) && wr_v && ws_v == sel) return wd_v;
        return regs_v[sel];
    endfunction

    // One clock: called at posedge+1 with inputs set; ends at next posedge+1.
    task automatic step();
        exp_t e;
        bit   acc;
        #1;
        for (int d = 0; d < ND; d++)
            check($sformatf("rd_ready[%0d]", d), {15'd0, rdy_s[d]}, {15'd0, (!m_held || ack_v)});
        acc = req_v && (!m_held || ack_v) && !reset;
        if (acc) begin
            m_count = m_count + 16'd1;
            for (int d = 0; d < ND; d++) begin
                e.a[d] = ref_val(d, sa_v);
                e.b[d] = ref_val(d, sb_v);
            end
            e.cnt = m_count;
            exp_q.push_back(e);
            m_held = 1'b1;
        end else if (m_held && ack_v && !reset) begin
            m_held = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++)
            check($sformatf("rd_valid[%0d]", d), {15'd0, val_s[d]}, {15'd0, m_held});
    endtask

    task automatic rand_regs();
        for (int i = 0; i < NUM_REGS; i++) regs_v[i] = 16'($urandom);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_held  = 1'b0;
        m_count = 16'h0000;
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("%s_valid[%0d]", tag, d), {15'd0, val_s[d]}, 16'h0000);
            check($sformatf("%s_data_a[%0d]", tag, d), da_s[d], 16'h0000);
            check($sformatf("%s_data_b[%0d]", tag, d), db_s[d], 16'h0000);
            check($sformatf("%s_count[%0d]", tag, d), cnt_s[d], 16'h0000);
        end
    endtask

    // Monitor: a fresh result must appear after every accept; otherwise the
    // held result must not move.
    always @(negedge clk) begin
        if (reset) begin
            acc_prev = '0;
        end else begin
            if (acc_prev != '0) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 16'd0, 16'd1);
                end else begin
                    last_e = exp_q.pop_front();
                    for (int d = 0; d < ND; d++) begin
                        check($sformatf("data_a[%0d]", d), da_s[d], last_e.a[d]);
                        check($sformatf("data_b[%0d]", d), db_s[d], last_e.b[d]);
                        check($sformatf("rd_count[%0d]", d), cnt_s[d], last_e.cnt);
                    end
                end
            end else begin
                for (int d = 0; d < ND; d++) begin
                    if (val_s[d]) begin
                        check($sformatf("held_a[%0d]", d), da_s[d], last_e.a[d]);
                        check($sformatf("held_b[%0d]", d), db_s[d], last_e.b[d]);
                        check($sformatf("held_count[%0d]", d), cnt_s[d], last_e.cnt);
                    end
                end
            end
            for (int d = 0; d < ND; d++) acc_prev[d] = rdy_s[d] & req_v;
        end
    end

    initial begin
        logic [15:0] cnt_before;
        reset = 1'b1;
        rand_regs();
        wr_v = 1'b0; ws_v = 4'd0; wd_v = 16'h0000;
        req_v = 1'b1; sa_v = 4'd1; sb_v = 4'd2; ack_v = 1'b0;
        #1;
        check_zero("reset");
        @(posedge clk); #1;
        step(); step();                       // requests during reset are dropped
        reset = 1'b0; req_v = 1'b0;
        step();

        // Basic two-port read
        regs_v[3] = 16'h1234; regs_v[7] = 16'hBEEF;
        req_v = 1'b1; sa_v = 4'd3; sb_v = 4'd7;
        step();
        for (int d = 0; d < ND; d++) begin
            check("basic_a", da_s[d], 16'h1234);
            check("basic_b", db_s[d], 16'hBEEF);
            check("basic_count", cnt_s[d], 16'h0001);
        end
        req_v = 1'b0; ack_v = 1'b1;
        step();

        // Same-cycle write bypass, both ports on the same register
        ack_v = 1'b0;
        regs_v[5] = 16'h0001; wr_v = 1'b1; ws_v = 4'd5; wd_v = 16'hCAFE;
        req_v = 1'b1; sa_v = 4'd5; sb_v = 4'd5;
        step();
        check("bypass_on", da_s[0], 16'hCAFE);
        check("bypass_off", da_s[1], 16'h0001);
        check("bypass_same_sel", db_s[0], 16'hCAFE);
        wr_v = 1'b0; req_v = 1'b0; ack_v = 1'b1;
        step();

        // Stall: held data frozen while reg3 is overwritten and requests ignored
        ack_v = 1'b0; req_v = 1'b1; sa_v = 4'd3; sb_v = 4'd3;
        step();
        cnt_before = cnt_s[0];
        for (int i = 0; i < 4; i++) begin
            regs_v[3] = 16'h5555; wr_v = 1'b1; ws_v = 4'd3; wd_v = 16'h5555;
            sa_v = 4'($urandom);
            step();
        end
        check("stall_a", da_s[0], 16'h1234);
        check("stall_count", cnt_s[0], cnt_before);
        wr_v = 1'b0;

        // Back-to-back reads through reg1, reg2, reg3
        rand_regs();
        ack_v = 1'b1; req_v = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            sa_v = 4'(i);
            step();
            check("b2b_a", da_s[1], regs_v[i]);
        end
        check("b2b_count", cnt_s[0], cnt_before + 16'd3);

        // Zero-r0 overrides a same-cycle write to register 0
        regs_v[0] = 16'hFFFF; wr_v = 1'b1; ws_v = 4'd0; wd_v = 16'h00AA; sa_v = 4'd0;
        step();
        check("zero_r0", da_s[2], 16'h0000);
        check("r0_bypass", da_s[0], 16'h00AA);
        check("r0_plain", da_s[1], 16'hFFFF);
        wr_v = 1'b0;

        // Asynchronous reset in the middle of a held read
        ack_v = 1'b0;
        step();
        #2;
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        model_reset();
        @(posedge clk); #1;
        step(); step();
        reset = 1'b0; req_v = 1'b0;
        step();

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) rand_regs();
            wr_v  = 1'($urandom);
            ws_v  = 4'($urandom);
            wd_v  = 16'($urandom);
            req_v = ($urandom_range(0, 3) != 0);
            ack_v = ($urandom_range(0, 2) != 0);
            sa_v  = ($urandom_range(0, 4) == 0) ? ws_v : 4'($urandom);
            sb_v  = ($urandom_range(0, 4) == 0) ? sa_v : 4'($urandom);
            step();
        end

        // Counter wrap: 65536 reads from a fresh reset
        req_v = 1'b0; ack_v = 1'b1; wr_v = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        step();
        req_v = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            sa_v = 4'($urandom); sb_v = 4'($urandom);
            step();
        end
        check("count_max", cnt_s[0], 16'hFFFF);
        step();
        for (int d = 0; d < ND; d++) check("count_wrap", cnt_s[d], 16'h0000);
        req_v = 1'b0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/reg_reader.md
REG_READER -- requirements
Module: reg_reader

Interface
REQ-001 Parameter BYPASS, default 1, meaning 1 = same-cycle write to the selected register is forwarded into the captured read data.
REQ-002 Parameter ZERO_R0, default 0, meaning 1 = selector 0 always reads 16'h0000.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 reg0..reg15  input  16 each  current register-file contents.
REQ-006 write  input  1  register-file write strobe (bypass snoop).
REQ-007 write_select  input  4  register-file write index (bypass snoop).
REQ-008 inputReg  input  16  register-file write data (bypass snoop).
REQ-009 rd_req  input  1  read request; sel_a and sel_b are valid when high.
REQ-010 sel_a  input  4  port A register index.
REQ-011 sel_b  input  4  port B register index.
REQ-012 rd_ready  output  1  reader can accept a request this cycle.
REQ-013 rd_valid  output  1  data_a and data_b hold a completed read.
REQ-014 data_a  output  16  port A read data, registered.
REQ-015 data_b  output  16  port B read data, registered.
REQ-016 rd_ack  input  1  consumer takes the current data this cycle.
REQ-017 rd_count  output  16  number of accepted requests, registered.

Function
REQ-018 FSM states: IDLE (no data held) and HOLD (rd_valid=1, data held).
REQ-019 rd_ready SHALL be combinational: (state==IDLE) | (state==HOLD & rd_ack).
REQ-020 Request accepted in a cycle where rd_req & rd_ready; the capture lands on the next posedge, so latency is 1 cycle from acceptance to rd_valid=1.
REQ-021 Captured port value SHALL be reg[sel] by default.
REQ-022 With BYPASS=1: if write & write_select==sel in the accept cycle, the captured value SHALL be inputReg.
REQ-023 With ZERO_R0=1: sel==0 SHALL capture 16'h0000, overriding bypass.
REQ-024 sel_a==sel_b is legal; both ports SHALL return identical values.
REQ-025 Transitions: IDLE & accept -> HOLD; HOLD & rd_ack & !rd_req -> IDLE (rd_valid falls next cycle); HOLD & rd_ack & rd_req -> HOLD with new data (back-to-back, 1 read/cycle throughput); HOLD & !rd_ack -> HOLD.
REQ-026 In HOLD without rd_ack, data_a and data_b SHALL stay frozen; later writes to the held registers are not reflected (snapshot semantics).
REQ-027 rd_req in HOLD without rd_ack SHALL be ignored: no capture and no count increment.
REQ-028 rd_ack in IDLE SHALL be ignored.
REQ-029 rd_count SHALL increment by 1 per accepted request and wrap from 16'hFFFF to 16'h0000.

Reset
REQ-030 While reset=1, asynchronously: state=IDLE, rd_valid=0, data_a=0, data_b=0, rd_count=0; rd_ready=1 as soon as reset is released.
REQ-031 Reset during HOLD SHALL discard the held read without completion.
REQ-032 A request coincident with reset SHALL be dropped.

Structure
REQ-033 Package reg_reader_pkg SHALL hold REG_W=16, SEL_W=4, NUM_REGS=16 and the IDLE/HOLD state enum.
REQ-034 Sub-module reg_sel_mux (16:1 select plus bypass and zero-r0 override, combinational) SHALL be instantiated once per port.

Verification
REQ-035 Reset release, reg3=16'h1234, reg7=16'hBEEF, rd_req with sel_a=3 and sel_b=7 -> next cycle rd_valid=1, data_a=16'h1234, data_b=16'hBEEF, rd_count=1.
REQ-036 Bypass: reg5=16'h0001, write=1, write_select=5, inputReg=16'hCAFE, rd_req with sel_a=5 in the same cycle -> data_a=16'hCAFE; repeat with BYPASS=0 -> data_a=16'h0001.
REQ-037 Stall: enter HOLD, hold rd_ack=0 for 4 cycles while rd_req=1 and reg3 is written to 16'h5555 -> rd_ready=0, data_a frozen at the old value, rd_count unchanged.
REQ-038 Back-to-back: rd_req=1 and rd_ack=1 for 3 cycles with sel_a=1,2,3 -> rd_valid stays 1, data_a steps through reg1, reg2, reg3 on consecutive cycles, rd_count=3.
REQ-039 Reset asserted mid-HOLD, asynchronously between clock edges -> rd_valid=0, data_a=data_b=0, rd_count=0 immediately; rd_ready=1 after release.
REQ-040 ZERO_R0=1, reg0=16'hFFFF, write to reg0 of 16'h00AA in the same cycle, sel_a=0 -> data_a=16'h0000; wrap: preload rd_count to 16'hFFFF via 65535 reads, one more read -> rd_count=16'h0000.
